// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Instruction class, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing command field, funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Result bus source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU B operand source
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Immediate extension format
  localparam logic [1:0] IMM_ROT8 = 2'b00;
  localparam logic [1:0] IMM_12   = 2'b01;
  localparam logic [1:0] IMM_24   = 2'b10;

  // Per-state control word before condition gating
  typedef struct packed {
    logic       irw;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } raw_ctrl_t;

  // ALU operation from the main decoder's aluop and the cmd field.
  // Unsupported commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic aluop, input logic [3:0] cmd);
    logic [1:0] ctl;
    ctl = ALU_ADD;
    if (aluop) begin
      case (cmd)
        CMD_ADD: ctl = ALU_ADD;
        CMD_SUB: ctl = ALU_SUB;
        CMD_AND: ctl = ALU_AND;
        CMD_ORR: ctl = ALU_ORR;
        default: ctl = ALU_ADD;
      endcase
    end
    return ctl;
  endfunction

  // Only true ADD/SUB commands produce meaningful carry and overflow
  function automatic logic cmd_is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  // Immediate format follows the instruction class; the undefined class
  // passes its op bits straight through.
  function automatic logic [1:0] imm_select(input logic [1:0] op);
    logic [1:0] sel;
    case (op)
      OP_DP:   sel = IMM_ROT8;
      OP_MEM:  sel = IMM_12;
      OP_BR:   sel = IMM_24;
      default: sel = OP_UND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Evaluates the instruction condition field against the stored NZCV flags.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags;

  // Condition decode; AL and the 1111 encoding always pass
  always_comb begin
    condex = 1'b1;
    case (cond)
      COND_EQ: condex = z_flag;
      COND_NE: condex = ~z_flag;
      COND_CS: condex = c_flag;
      COND_CC: condex = ~c_flag;
      COND_MI: condex = n_flag;
      COND_PL: condex = ~n_flag;
      COND_VS: condex = v_flag;
      COND_VC: condex = ~v_flag;
      COND_HI: condex = c_flag & ~z_flag;
      COND_LS: condex = ~c_flag | z_flag;
      COND_GE: condex = (n_flag == v_flag);
      COND_LT: condex = (n_flag != v_flag);
      COND_GT: condex = ~z_flag & (n_flag == v_flag);
      COND_LE: condex = z_flag | (n_flag != v_flag);
      default: condex = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM main controller: Moore FSM sequencing fetch through
// writeback, NZCV flag register and condition gating of all writes.
module multicycle_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] aluflags,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] alucontrol,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       condex_q;
  logic       condex;
  logic       condex_gate;
  logic       in_exec;
  logic       wr_allow;
  logic       rd_is_pc;
  raw_ctrl_t  ctrl;

  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;

  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags_q),
    .condex (condex)
  );

  // State, flag and delayed-condition registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Raw Moore control word for the current state
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.irw       = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.adrsrc    = 1'b0;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.aluop     = 1'b0;
      end
      S_DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_EXTIMM;
        ctrl.aluop   = 1'b0;
      end
      S_MEMRD: begin
        ctrl.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alusrcb = SRCB_RD2;
        ctrl.aluop   = 1'b1;
      end
      S_EXECI: begin
        ctrl.alusrcb = SRCB_EXTIMM;
        ctrl.aluop   = 1'b1;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = 1'b0;
        ctrl.alusrcb   = SRCB_EXTIMM;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  // Flag update: NZ on any S-suffixed executed instruction, CV only
  // when the command is a real ADD or SUB.
  always_comb begin
    flags_d = flags_q;
    if (in_exec && s_bit && condex) begin
      flags_d[3:2] = aluflags[3:2];
      if (cmd_is_arith(cmd)) begin
        flags_d[1:0] = aluflags[1:0];
      end
    end
  end

  // ALUWB follows the flag-setting EXEC cycle, so it must see the condition
  // as evaluated before that update; everywhere else flags are stable.
  assign condex_gate = (state_q == S_ALUWB) ? condex_q : condex;

  // Write strobes are held off for the whole time reset is asserted
  assign wr_allow = ~reset;
  assign rd_is_pc = (rd == 4'hF);

  // Gated strobes and pass-through datapath selects
  always_comb begin
    pcwrite    = wr_allow & (ctrl.nextpc
                             | (ctrl.branch & condex_gate)
                             | (ctrl.regw & condex_gate & rd_is_pc));
    regwrite   = wr_allow & ctrl.regw & condex_gate;
    memwrite   = wr_allow & ctrl.memw & condex_gate;
    irwrite    = wr_allow & ctrl.irw;
    adrsrc     = ctrl.adrsrc;
    resultsrc  = ctrl.resultsrc;
    alusrca    = ctrl.alusrca;
    alusrcb    = ctrl.alusrcb;
    alucontrol = alu_decode(ctrl.aluop, cmd);
    immsrc     = imm_select(op);
    regsrc     = {(op == OP_MEM), (op == OP_BR)};
  end

endmodule
